// File: rtl/serial_sub_unit.sv
// Bit-serial subtractor: diff = sum - {0,a}, one bit per clock, LSB first.
// Optional underflow statistics counter behind SERIAL_SUB_STATS_EN.
module serial_sub_unit #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff,
    output logic             underflow
`ifdef SERIAL_SUB_STATS_EN
    ,
    output logic [7:0]       uf_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_s;
    logic [WIDTH:0]   r_diff;
    logic             r_borrow;
    logic             r_underflow;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_last;
    logic w_release;
    logic w_d;
    logic w_borrow_nx;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_last    = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH));
    assign w_release = (r_state == DONE) && out_ready;

    // One full-subtractor cell on the current LSBs
    assign w_d         = r_m[0] ^ r_s[0] ^ r_borrow;
    assign w_borrow_nx = (~r_m[0] & r_s[0])
                       | (~(r_m[0] ^ r_s[0]) & r_borrow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = SHIFT;
            SHIFT:   if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m         <= '0;
            r_s         <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_underflow <= 1'b0;
        end else if (w_accept) begin
            r_m      <= sum;
            r_s      <= {1'b0, a};
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_diff   <= {w_d, r_diff[WIDTH:1]};
            r_m      <= {1'b0, r_m[WIDTH:1]};
            r_s      <= {1'b0, r_s[WIDTH:1]};
            r_borrow <= w_borrow_nx;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_underflow <= w_borrow_nx;
            end
        end
    end

    assign diff      = r_diff;
    assign underflow = r_underflow;

`ifdef SERIAL_SUB_STATS_EN
    logic [7:0] r_uf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uf_count <= '0;
        end else if (w_release && r_underflow && (r_uf_count != 8'hFF)) begin
            r_uf_count <= r_uf_count + 8'd1;
        end
    end

    assign uf_count = r_uf_count;
`endif

endmodule
